// File: rtl/screen_pkg.sv
// Shared types and default geometry for the rectangle-fill engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package screen_pkg;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int DEF_X_W      = 8;
  localparam int DEF_Y_W      = 7;
  localparam int DEF_COLOR_W  = 3;

  typedef enum logic [1:0] {
    SOLID      = 2'd0,
    ROW_STRIPE = 2'd1,
    COL_STRIPE = 2'd2,
    CLEAR      = 2'd3
  } fill_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/span_counter.sv
// Loadable span counter: counts start..end, wraps back to start after end.
// Latency: one cycle from load/enable to new count.
// Backpressure: holds its count whenever i_en is low.
module span_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [N-1:0] i_start,
  input  logic [N-1:0] i_end,
  input  logic         i_en,
  output logic [N-1:0] o_cnt,
  output logic         o_term
);

  localparam logic [N-1:0] ONE = 1;

  logic [N-1:0] r_cnt;
  logic [N-1:0] r_start;
  logic [N-1:0] r_end;

  // Load captures the span bounds; enable steps, wrapping to the start at the end value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_start <= '0;
      r_end   <= '0;
    end else if (i_load) begin
      r_cnt   <= i_start;
      r_start <= i_start;
      r_end   <= i_end;
    end else if (i_en) begin
      r_cnt <= (r_cnt == r_end) ? r_start : r_cnt + ONE;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_term = (r_cnt == r_end);

endmodule

// File: rtl/screen_fill_engine.sv
// Rectangle fill: raster-scans a screen-clipped rectangle, one pixel per accepted cycle.
// Latency: first pixel the cycle after start; done one cycle after the last accepted pixel.
// Backpressure: ready low freezes x/y/color with plot held high.
module screen_fill_engine #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [X_W-1:0]     w,
  input  logic [Y_W-1:0]     h,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               ready,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COLOR_W-1:0] color,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  import screen_pkg::*;

  // Bounds held one bit wider than the coordinates so origin+size never wraps.
  localparam logic [X_W:0] X_ONE  = 1;
  localparam logic [Y_W:0] Y_ONE  = 1;
  localparam logic [X_W:0] X_LIM  = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIM  = (Y_W+1)'(SCREEN_H);
  localparam logic [X_W:0] X_LAST = (X_W+1)'(SCREEN_W - 1);
  localparam logic [Y_W:0] Y_LAST = (Y_W+1)'(SCREEN_H - 1);

  fill_state_t          r_state;
  fill_state_t          w_state_nxt;
  fill_mode_t           r_mode;
  logic [COLOR_W-1:0]   r_color;

  logic [X_W:0]         w_x_sum;
  logic [Y_W:0]         w_y_sum;
  logic [X_W-1:0]       w_x_end;
  logic [Y_W-1:0]       w_y_end;
  logic                 w_empty;
  logic                 w_accept_start;
  logic                 w_load;
  logic                 w_x_en;
  logic                 w_y_en;
  logic                 w_x_term;
  logic                 w_y_term;
  logic                 w_last;
  logic [X_W-1:0]       w_x_cnt;
  logic [Y_W-1:0]       w_y_cnt;
  logic [COLOR_W-1:0]   w_color;

  // Clip arithmetic; only meaningful when the rectangle is non-empty (w,h >= 1).
  assign w_x_sum = {1'b0, x0} + {1'b0, w} - X_ONE;
  assign w_y_sum = {1'b0, y0} + {1'b0, h} - Y_ONE;
  assign w_x_end = (w_x_sum > X_LAST) ? X_LAST[X_W-1:0] : w_x_sum[X_W-1:0];
  assign w_y_end = (w_y_sum > Y_LAST) ? Y_LAST[Y_W-1:0] : w_y_sum[Y_W-1:0];
  assign w_empty = (w == '0) || (h == '0) || ({1'b0, x0} >= X_LIM) || ({1'b0, y0} >= Y_LIM);

  assign w_accept_start = (r_state == IDLE) && start;
  assign w_load         = w_accept_start && !w_empty;
  assign w_x_en         = (r_state == FILL) && ready;
  assign w_y_en         = w_x_en && w_x_term;
  assign w_last         = w_y_en && w_y_term;

  span_counter #(.N(X_W)) u_x_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_start (x0),
    .i_end   (w_x_end),
    .i_en    (w_x_en),
    .o_cnt   (w_x_cnt),
    .o_term  (w_x_term)
  );

  span_counter #(.N(Y_W)) u_y_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_start (y0),
    .i_end   (w_y_end),
    .i_en    (w_y_en),
    .o_cnt   (w_y_cnt),
    .o_term  (w_y_term)
  );

  // State register plus the per-fill mode/colour captured when a start is taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_mode  <= SOLID;
      r_color <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept_start) begin
        r_mode  <= fill_mode_t'(mode);
        r_color <= color_in;
      end
    end
  end

  // Next state: empty rectangles skip straight to the completion pulse.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = w_empty ? DONE : FILL;
      FILL:    if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pixel colour decoded from the latched mode and the current coordinates.
  always_comb begin
    w_color = '0;
    case (r_mode)
      SOLID:      w_color = r_color;
      ROW_STRIPE: w_color = w_y_cnt[COLOR_W-1:0];
      COL_STRIPE: w_color = w_x_cnt[COLOR_W-1:0];
      default:    w_color = '0;
    endcase
  end

  assign x     = w_x_cnt;
  assign y     = w_y_cnt;
  assign color = w_color;
  assign plot  = (r_state == FILL);
  assign busy  = (r_state != IDLE);
  assign done  = (r_state == DONE);

endmodule

// File: tb/tb_screen_fill_engine.sv
// Self-checking bench for screen_fill_engine: table of fills, random fills, reset corner.
// Latency: n/a.
// Backpressure: ready driven per-fill as constant, 1-0-0 pattern, or random.
module tb_screen_fill_engine;

  localparam int SW = 160;
  localparam int SH = 120;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [7:0] w;
  logic [6:0] h;
  logic [1:0] mode;
  logic [2:0] color_in;
  logic       ready;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;
  logic       plot;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_pass = 0;

  screen_fill_engine #(
    .SCREEN_W (SW),
    .SCREEN_H (SH),
    .X_W      (8),
    .Y_W      (7),
    .COLOR_W  (3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .w        (w),
    .h        (h),
    .mode     (mode),
    .color_in (color_in),
    .ready    (ready),
    .x        (x),
    .y        (y),
    .color    (color),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // rdy: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.  poke: fill cycle to re-pulse start (-1 none).
  typedef struct {
    int x0, y0, w, h, mode, col, rdy, poke;
    int exp_n, exp_lx, exp_ly;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] pix(input int px, input int py, input int pc);
    return 32'((px << 16) | (py << 8) | pc);
  endfunction

  // Runs one fill; returns accepted-pixel count and the last accepted coordinate as seen on the DUT.
  task automatic run_fill(input vec_t v, output int n_acc, output int lx, output int ly);
    logic [31:0] q[$];
    int          xe, ye, pc, cyc, budget;
    bit          fin;
    q = {};
    if (v.w > 0 && v.h > 0 && v.x0 < SW && v.y0 < SH) begin
      xe = (v.x0 + v.w - 1 < SW - 1) ? v.x0 + v.w - 1 : SW - 1;
      ye = (v.y0 + v.h - 1 < SH - 1) ? v.y0 + v.h - 1 : SH - 1;
      for (int yy = v.y0; yy <= ye; yy++) begin
        for (int xx = v.x0; xx <= xe; xx++) begin
          case (v.mode)
            0:       pc = v.col;
            1:       pc = yy % 8;
            2:       pc = xx % 8;
            default: pc = 0;
          endcase
          q.push_back(pix(xx, yy, pc));
        end
      end
    end
    budget = 4 * q.size() + 50;
    n_acc = 0; lx = -1; ly = -1;

    @(negedge clk);
    x0 = 8'(v.x0); y0 = 7'(v.y0); w = 8'(v.w); h = 7'(v.h);
    mode = 2'(v.mode); color_in = 3'(v.col); start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Inputs wander after the latch; the fill must not notice.
    x0 = 8'($urandom); y0 = 7'($urandom); w = 8'($urandom); h = 7'($urandom);
    mode = 2'($urandom); color_in = 3'($urandom);
    cyc = 1; fin = 1'b0;
    while (!fin) begin
      if (done === 1'b1 || plot !== 1'b1 || cyc > budget) begin
        start = 1'b0;
        chk("done_flags", {29'd0, plot, busy, done}, 32'b011);
        chk("done_timing_remaining", q.size(), 0);
        @(negedge clk);
        chk("idle_flags", {29'd0, plot, busy, done}, 32'b000);
        fin = 1'b1;
      end else begin
        chk("fill_flags", {29'd0, plot, busy, done}, 32'b110);
        chk("pixel", pix(int'(x), int'(y), int'(color)), (q.size() > 0) ? q[0] : 32'hFFFF_FFFF);
        case (v.rdy)
          0:       ready = 1'b1;
          1:       ready = ((cyc - 1) % 3 == 0);
          default: ready = ($urandom_range(0, 3) != 0);
        endcase
        if (ready) begin
          n_acc++; lx = int'(x); ly = int'(y);
          if (q.size() > 0) void'(q.pop_front());
        end
        start = (cyc == v.poke);
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  vec_t tbl[10];
  vec_t rv;
  int   na, lx, ly;

  initial begin
    // Hand-derived expectations: count of accepted pixels and last accepted (x,y).
    tbl[0] = '{0,   0,   160, 120, 0, 5, 0, -1, 19200, 159, 119};
    tbl[1] = '{150, 115, 20,  10,  1, 0, 2, -1, 50,    159, 119};
    tbl[2] = '{3,   4,   2,   2,   0, 6, 1, -1, 4,     4,   5};
    tbl[3] = '{10,  10,  0,   5,   0, 1, 0, -1, 0,     -1,  -1};
    tbl[4] = '{200, 10,  5,   5,   0, 1, 0, -1, 0,     -1,  -1};
    tbl[5] = '{6,   0,   4,   1,   2, 0, 0, 2,  4,     9,   0};
    tbl[6] = '{5,   119, 3,   0,   3, 0, 0, -1, 0,     -1,  -1};
    tbl[7] = '{5,   120, 3,   3,   0, 2, 0, -1, 0,     -1,  -1};
    tbl[8] = '{159, 119, 1,   1,   3, 7, 2, -1, 1,     159, 119};
    tbl[9] = '{0,   3,   255, 1,   2, 0, 2, 3,  160,   159, 3};

    reset_n = 1'b0; start = 1'b0; ready = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; mode = '0; color_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {11'd0, x, y, color, plot, busy, done}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_fill(tbl[i], na, lx, ly);
      chk($sformatf("vec%0d_count", i), na, tbl[i].exp_n);
      chk($sformatf("vec%0d_last", i), pix(lx, ly, 0), pix(tbl[i].exp_lx, tbl[i].exp_ly, 0));
    end

    // Reset dropped asynchronously mid-fill, between clock edges.
    @(negedge clk);
    x0 = 8'd20; y0 = 7'd30; w = 8'd10; h = 7'd10; mode = 2'd0; color_in = 3'd7;
    start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_outputs", {11'd0, x, y, color, plot, busy, done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rv = '{5, 6, 3, 2, 1, 0, 2, -1, 6, 7, 7};
    run_fill(rv, na, lx, ly);
    chk("post_reset_count", na, rv.exp_n);
    chk("post_reset_last", pix(lx, ly, 0), pix(rv.exp_lx, rv.exp_ly, 0));

    // Random rectangles, some straddling or beyond the screen edges.
    for (int i = 0; i < 40; i++) begin
      rv.x0 = $urandom_range(0, 170); rv.y0 = $urandom_range(0, 127);
      rv.w = $urandom_range(0, 14);   rv.h = $urandom_range(0, 9);
      rv.mode = $urandom_range(0, 3); rv.col = $urandom_range(0, 7);
      rv.rdy = $urandom_range(0, 2);  rv.poke = $urandom_range(1, 8);
      rv.exp_n = 0; rv.exp_lx = -1; rv.exp_ly = -1;
      run_fill(rv, na, lx, ly);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/screen_fill_engine.md
# screen_fill_engine

Parametrised rectangle-fill engine for the pixel-plotting path of the display subsystem. Given a start pulse and a rectangle (origin, width, height, fill mode), it raster-scans the rectangle clipped to the screen and emits one `x`/`y`/`color`/`plot` pixel per accepted cycle. It supports downstream back-pressure and reports busy/done. It generalises the fixed 160×120 full-screen clear into arbitrary regions, screen sizes and fill modes.

## Interface
- `SCREEN_W`, 160: visible columns.
- `SCREEN_H`, 120: visible rows.
- `X_W`, 8: x coordinate and width field width; must satisfy 2^X_W ≥ SCREEN_W.
- `Y_W`, 7: y coordinate and height field width; must satisfy 2^Y_W ≥ SCREEN_H.
- `COLOR_W`, 3: colour width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a fill; sampled only in IDLE.
- `x0`  in  X_W  rectangle left column.
- `y0`  in  Y_W  rectangle top row.
- `w`  in  X_W  rectangle width in pixels.
- `h`  in  Y_W  rectangle height in pixels.
- `mode`  in  2  fill mode: 0 SOLID, 1 ROW_STRIPE, 2 COL_STRIPE, 3 CLEAR.
- `color_in`  in  COLOR_W  colour for SOLID.
- `ready`  in  1  downstream accepts the current pixel this cycle.
- `x`  out  X_W  current pixel column.
- `y`  out  Y_W  current pixel row.
- `color`  out  COLOR_W  current pixel colour.
- `plot`  out  1  pixel valid.
- `busy`  out  1  high in FILL and DONE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE → FILL → DONE → IDLE.
- IDLE + `start`: latch `x0`, `y0`, `mode` and `color_in`; compute clipped bounds.
  - `x_end = min(x0+w-1, SCREEN_W-1)`, `y_end = min(y0+h-1, SCREEN_H-1)`.
  - Sums are computed at X_W+1 / Y_W+1 bits, so they never wrap.
- Empty rectangle (`w==0`, `h==0`, `x0≥SCREEN_W` or `y0≥SCREEN_H`): go directly to DONE. No `plot` is emitted.
- FILL: `plot=1`, with `x`/`y` at the current pixel.
  - When `plot&ready`, advance x. At `x==x_end`, x reloads `x0` and y increments.
  - Accepting pixel (`x_end`,`y_end`) moves to DONE.
  - With `ready=0`, `x`/`y`/`color` hold stable.
- Colour per mode:
  - SOLID: latched `color_in`.
  - ROW_STRIPE: `y[COLOR_W-1:0]`.
  - COL_STRIPE: `x[COLOR_W-1:0]`.
  - CLEAR: 0.
- DONE: `done=1` for exactly one cycle, `plot=0`, then IDLE.
- `start` outside IDLE is ignored, not queued. Input changes after the latch have no effect.
- Outputs in IDLE: `plot=0`, `busy=0`, `done=0`. `x`/`y` hold their last value.
- Reset values (async, any state, including mid-fill): state IDLE, `x=0`, `y=0`, `color=0`, `plot=0`, `busy=0`, `done=0`.

## Timing
- `start` at edge n: FILL from n+1, first pixel (`x0`,`y0`) presented in cycle n+1.
- Empty rectangle: `done` in cycle n+1.
- Throughput: one pixel per cycle while `ready=1`. A full screen at default parameters takes 19200 `plot&ready` cycles.
- Last pixel accepted at edge m: `done=1` in cycle m+1; IDLE at m+2.
- Earliest next `start` is sampled at m+2.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.

## Structure
- Package `screen_pkg`:
  - `fill_mode_t` enum (SOLID, ROW_STRIPE, COL_STRIPE, CLEAR).
  - `fill_state_t` enum (IDLE, FILL, DONE).
  - Default screen constants.
- Sub-module `span_counter #(N)`: counter with enable, synchronous load of a start value, and a terminal flag at a programmable end value. It is instantiated twice, for x and y, with y's enable driven by x's terminal flag.
- Top level holds the FSM, the clip arithmetic and the colour mux.

## Test plan
- Full screen: x0=0,y0=0,w=160,h=120,SOLID color_in=5,ready=1.
  - Expect 19200 plots, raster order, every color=5.
  - Last pixel (159,119); `done` 1 cycle later.
- Clip: x0=150,y0=115,w=20,h=10,ROW_STRIPE.
  - Expect 10×5=50 plots over x 150..159, y 115..119.
  - Colour equals y[2:0].
- Back-pressure: 2×2 at (3,4), `ready` toggled 1,0,0,1,...
  - `x`/`y`/`color` stay stable while `ready=0`.
  - Exactly 4 accepted pixels: (3,4),(4,4),(3,5),(4,5).
- Empty: w=0, and separately x0=200.
  - `done` in cycle n+1, `plot` never asserted.
- Busy/start: `start` pulsed mid-fill, COL_STRIPE 4×1 at (6,0).
  - Second `start` ignored; colours 6,7,0,1; `busy` high from n+1 through the DONE cycle.
- Reset: `reset_n` asserted mid-fill, asynchronously between edges.
  - All outputs return to 0 immediately.
  - A subsequent `start` begins cleanly at its own origin.
